// File: rtl/encoder64_6_sar.sv
// Two-stage pipelined 64-to-6 priority encoder (bit 0 highest priority) with
// valid/ready handshake, zero/multi-hot flags and a saturating multi-hot counter.
module encoder64_6_sar #(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [63:0]          in_vec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [5:0]           out_code,
    output logic                 out_zero,
    output logic                 out_multi,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 err_clr
);

    localparam int unsigned VEC_W  = 64;
    localparam int unsigned GRP_N  = 8;
    localparam int unsigned GRP_W  = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned GSEL_W = 3;
    localparam int unsigned CODE_W = 6;

    logic                           en;
    logic [GRP_N-1:0]               grp_any;
    logic [GRP_N-1:0][IDX_W-1:0]    grp_idx;
    logic                           vec_multi;
    logic                           s1_valid;
    logic [GRP_N-1:0]               s1_any;
    logic [GRP_N-1:0][IDX_W-1:0]    s1_idx;
    logic                           s1_multi;
    logic [CODE_W-1:0]              code_nxt;
    logic                           zero_nxt;

    // Whole pipeline moves together; no skid buffer, so ready is combinational.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Per-group any-set flag and local index of the lowest set bit.
    always_comb begin
        grp_any = '0;
        grp_idx = '0;
        for (int g = 0; g < int'(GRP_N); g++) begin
            grp_any[g] = |in_vec[g*GRP_W +: GRP_W];
            for (int b = int'(GRP_W) - 1; b >= 0; b--) begin
                if (in_vec[g*GRP_W + b]) begin
                    grp_idx[g] = IDX_W'(b);
                end
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign vec_multi = |(in_vec & (in_vec - VEC_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_any   <= '0;
            s1_idx   <= '0;
            s1_multi <= 1'b0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_any   <= grp_any;
            s1_idx   <= grp_idx;
            s1_multi <= vec_multi;
        end
    end

    // Lowest group with a set bit selects the upper code bits.
    always_comb begin
        code_nxt = '0;
        zero_nxt = 1'b1;
        for (int g = int'(GRP_N) - 1; g >= 0; g--) begin
            if (s1_any[g]) begin
                code_nxt = {GSEL_W'(g), s1_idx[g]};
                zero_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_code  <= '0;
            out_zero  <= 1'b0;
            out_multi <= 1'b0;
        end else if (en) begin
            out_valid <= s1_valid;
            out_code  <= code_nxt;
            out_zero  <= zero_nxt;
            out_multi <= s1_multi;
        end
    end

    // Counts accepted multi-hot results; clear wins over increment, no wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (out_valid && out_ready && out_multi && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_encoder64_6_sar.sv
// Directed bench for encoder64_6_sar: one-hot sweep, zero and multi-hot inputs,
// backpressure, counter saturation/clear and asynchronous reset mid-flight.
module tb_encoder64_6_sar;

    localparam int unsigned ERR_W = 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_vec;
    logic             out_valid;
    logic             out_ready;
    logic [5:0]       out_code;
    logic             out_zero;
    logic             out_multi;
    logic [ERR_W-1:0] err_cnt;
    logic             err_clr;

    int n_checks;
    int n_fail;
    int exp_err;

    encoder64_6_sar #(.ERR_CNT_W(ERR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_zero  (out_zero),
        .out_multi (out_multi),
        .err_cnt   (err_cnt),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference one-hot decode of a 6-bit code.
    function automatic logic [63:0] dec6(input logic [5:0] code);
        logic [63:0] one;
        one = 64'd1;
        return one << code;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_and_wait(input logic [63:0] v);
        in_valid = 1'b1;
        in_vec   = v;
        step();
        in_valid = 1'b0;
        in_vec   = '0;
        step();
    endtask

    task automatic test_reset();
        n_checks++;
        if ({out_valid, out_code, out_zero, out_multi} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b c=%0d z=%b m=%b exp all 0",
                     out_valid, out_code, out_zero, out_multi);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready got %b exp 1", in_ready);
        end
        n_checks++;
        if (err_cnt !== ERR_W'(0)) begin
            n_fail++;
            $display("FAIL reset_err_cnt got %0d exp 0", err_cnt);
        end
    endtask

    task automatic test_sweep();
        logic [63:0] one;
        one = 64'd1;
        for (int c = 0; c <= 65; c++) begin
            in_valid = (c < 64);
            in_vec   = (c < 64) ? (one << c) : 64'd0;
            step();
            if (c >= 1 && c <= 64) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_code !== 6'(c - 1)) begin
                    n_fail++;
                    $display("FAIL sweep_code k=%0d got v=%b code=%0d exp v=1 code=%0d",
                             c - 1, out_valid, out_code, c - 1);
                end
                n_checks++;
                if (dec6(out_code) !== (one << (c - 1))) begin
                    n_fail++;
                    $display("FAIL sweep_redecode k=%0d got %h exp %h",
                             c - 1, dec6(out_code), one << (c - 1));
                end
                n_checks++;
                if (out_zero !== 1'b0 || out_multi !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sweep_flags k=%0d got z=%b m=%b exp z=0 m=0",
                             c - 1, out_zero, out_multi);
                end
            end
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_drain got out_valid=%b exp 0", out_valid);
        end
        n_checks++;
        if (err_cnt !== ERR_W'(exp_err)) begin
            n_fail++;
            $display("FAIL sweep_err_cnt got %0d exp %0d", err_cnt, exp_err);
        end
    endtask

    task automatic test_zero();
        send_and_wait(64'd0);
        n_checks++;
        if (out_valid !== 1'b1 || out_zero !== 1'b1 || out_code !== 6'd0 || out_multi !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_result got v=%b z=%b c=%0d m=%b exp v=1 z=1 c=0 m=0",
                     out_valid, out_zero, out_code, out_multi);
        end
        step();
        n_checks++;
        if (err_cnt !== ERR_W'(exp_err)) begin
            n_fail++;
            $display("FAIL zero_err_cnt got %0d exp %0d", err_cnt, exp_err);
        end
    endtask

    task automatic test_multi();
        logic [63:0] v [2];
        logic [5:0]  exp_code [2];
        v[0] = 64'd0; v[0][5] = 1'b1; v[0][40] = 1'b1; exp_code[0] = 6'd5;
        v[1] = 64'd0; v[1][8] = 1'b1; v[1][63] = 1'b1; exp_code[1] = 6'd8;
        for (int i = 0; i < 2; i++) begin
            send_and_wait(v[i]);
            n_checks++;
            if (out_valid !== 1'b1 || out_code !== exp_code[i] || out_multi !== 1'b1 || out_zero !== 1'b0) begin
                n_fail++;
                $display("FAIL multi_result[%0d] got v=%b c=%0d m=%b z=%b exp v=1 c=%0d m=1 z=0",
                         i, out_valid, out_code, out_multi, out_zero, exp_code[i]);
            end
            step();
            exp_err = (exp_err == 3) ? 3 : exp_err + 1;
            n_checks++;
            if (err_cnt !== ERR_W'(exp_err)) begin
                n_fail++;
                $display("FAIL multi_err_cnt[%0d] got %0d exp %0d", i, err_cnt, exp_err);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] one;
        one = 64'd1;
        in_valid = 1'b1;
        in_vec   = one << 3;
        step();
        in_vec   = one << 4;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_code !== 6'd3) begin
            n_fail++;
            $display("FAIL bp_first got v=%b c=%0d exp v=1 c=3", out_valid, out_code);
        end
        out_ready = 1'b0;
        in_vec    = one << 5;
        #1;
        for (int s = 0; s < 4; s++) begin
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_code !== 6'd3) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got rdy=%b v=%b c=%0d exp rdy=0 v=1 c=3",
                         s, in_ready, out_valid, out_code);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        in_vec   = '0;
        n_checks++;
        if (out_valid !== 1'b1 || out_code !== 6'd4) begin
            n_fail++;
            $display("FAIL bp_second got v=%b c=%0d exp v=1 c=4", out_valid, out_code);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_code !== 6'd5) begin
            n_fail++;
            $display("FAIL bp_third got v=%b c=%0d exp v=1 c=5", out_valid, out_code);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_dup got out_valid=%b exp 0", out_valid);
        end
    endtask

    task automatic test_saturate();
        int exp_seq [5];
        logic [63:0] mv;
        exp_seq = '{1, 2, 3, 3, 3};
        mv = 64'h8000_0000_0000_0003;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        exp_err = 0;
        n_checks++;
        if (err_cnt !== ERR_W'(0)) begin
            n_fail++;
            $display("FAIL sat_clear got %0d exp 0", err_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            send_and_wait(mv);
            step();
            exp_err = exp_seq[i];
            n_checks++;
            if (err_cnt !== ERR_W'(exp_err)) begin
                n_fail++;
                $display("FAIL sat_count[%0d] got %0d exp %0d", i, err_cnt, exp_err);
            end
        end
        send_and_wait(mv);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        exp_err = 0;
        n_checks++;
        if (err_cnt !== ERR_W'(0)) begin
            n_fail++;
            $display("FAIL sat_clr_priority got %0d exp 0", err_cnt);
        end
    endtask

    task automatic test_async_reset();
        logic [63:0] va;
        va = 64'h0000_0000_0000_0080;
        in_valid = 1'b1;
        in_vec   = va;
        step();
        in_vec   = 64'h0000_0100_0000_0000;
        step();
        in_valid = 1'b0;
        in_vec   = '0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_code, out_zero, out_multi} !== 9'd0 || in_ready !== 1'b1 || err_cnt !== ERR_W'(0)) begin
            n_fail++;
            $display("FAIL async_reset got v=%b c=%0d z=%b m=%b rdy=%b err=%0d exp zeros rdy=1",
                     out_valid, out_code, out_zero, out_multi, in_ready, err_cnt);
        end
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL async_stale[%0d] got out_valid=%b exp 0", i, out_valid);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        exp_err   = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        #1;
        test_reset();
        #10;
        rst_n = 1'b1;
        step();
        test_sweep();
        test_zero();
        test_multi();
        test_backpressure();
        test_saturate();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
